// File: rtl/mem_fill_arbiter_if.sv
// Cache-fill / memory bus bundle for mem_fill_arbiter.
// Cache side: ic/dc fill requests with block address, write-through store
//   request, per-requester busy/data_valid/done, shared fill_word/fill_data,
//   store acknowledge.
// Memory side: mem_enable/mem_wr/mem_addr/mem_data_out strobes out,
//   mem_data_in/mem_data_valid read returns in.
// modport master: the arbiter. modport slave: caches plus memory model.
interface mem_fill_arbiter_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;

    logic              ic_busy;
    logic              dc_busy;
    logic              ic_data_valid;
    logic              dc_data_valid;
    logic [IDX_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              ic_done;
    logic              dc_done;
    logic              st_ack;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr, st_req, st_addr, st_data,
        input  mem_data_in, mem_data_valid,
        output ic_busy, dc_busy, ic_data_valid, dc_data_valid,
        output fill_word, fill_data, ic_done, dc_done, st_ack,
        output mem_enable, mem_wr, mem_addr, mem_data_out
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr, st_req, st_addr, st_data,
        output mem_data_in, mem_data_valid,
        input  ic_busy, dc_busy, ic_data_valid, dc_data_valid,
        input  fill_word, fill_data, ic_done, dc_done, st_ack,
        input  mem_enable, mem_wr, mem_addr, mem_data_out
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates one pipelined main memory between I-cache fills, D-cache fills
// and D-cache write-through stores. A granted fill becomes 8 word reads
// (base+0,2,..,14), one per cycle; returns are steered to the owner with a
// word index and a done pulse on the last word.
// Ports: clk, rst (sync, active high), bus (mem_fill_arbiter_if.master).
module mem_fill_arbiter #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned WORDS   = 8
) (
    input logic                clk,
    input logic                rst,
    mem_fill_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, STORE} state_t;
    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           rr_last_q, rr_last_d;
    logic [15:0]      base_q, base_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic             ic_busy_q, ic_busy_d;
    logic             dc_busy_q, dc_busy_d;
    logic             mem_enable_q, mem_enable_d;
    logic             mem_wr_q, mem_wr_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_data_out_q, mem_data_out_d;
    logic             st_ack_q, st_ack_d;

    logic             grant_dc_c;
    logic             ret_valid_c;
    logic             last_ret_c;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IC;
            rr_last_q      <= OWN_DC;
            base_q         <= '0;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            ic_busy_q      <= 1'b0;
            dc_busy_q      <= 1'b0;
            mem_enable_q   <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            st_ack_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_last_q      <= rr_last_d;
            base_q         <= base_d;
            issue_cnt_q    <= issue_cnt_d;
            ret_cnt_q      <= ret_cnt_d;
            ic_busy_q      <= ic_busy_d;
            dc_busy_q      <= dc_busy_d;
            mem_enable_q   <= mem_enable_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            st_ack_q       <= st_ack_d;
        end
    end

    // Arbitration, issue sequencing and return tracking.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_last_d      = rr_last_q;
        base_d         = base_q;
        issue_cnt_d    = issue_cnt_q;
        ret_cnt_d      = ret_cnt_q;
        ic_busy_d      = ic_busy_q;
        dc_busy_d      = dc_busy_q;
        mem_enable_d   = 1'b0;
        mem_wr_d       = 1'b0;
        mem_addr_d     = '0;
        mem_data_out_d = '0;
        st_ack_d       = 1'b0;
        grant_dc_c     = 1'b0;
        ret_valid_c    = 1'b0;
        last_ret_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    // Fills beat stores; a fill tie goes to whoever was not served last.
                    grant_dc_c   = bus.dc_req && (!bus.ic_req || rr_last_q == OWN_IC);
                    owner_d      = grant_dc_c ? OWN_DC : OWN_IC;
                    base_d       = (grant_dc_c ? bus.dc_addr : bus.ic_addr) & 16'hFFF0;
                    ic_busy_d    = !grant_dc_c;
                    dc_busy_d    = grant_dc_c;
                    issue_cnt_d  = '0;
                    ret_cnt_d    = '0;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = base_d;
                    state_d      = ISSUE;
                end else if (bus.st_req) begin
                    mem_enable_d   = 1'b1;
                    mem_wr_d       = 1'b1;
                    mem_addr_d     = bus.st_addr;
                    mem_data_out_d = bus.st_data;
                    st_ack_d       = 1'b1;
                    state_d        = STORE;
                end
            end
            ISSUE: begin
                // Word issue_cnt_q is on the bus now; queue up the next one.
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d  = issue_cnt_q + CNT_W'(1);
                    mem_enable_d = 1'b1;
                    // base low nibble is zero, so this never carries out of the block.
                    mem_addr_d   = base_q + 16'({issue_cnt_d, 1'b0});
                end
            end
            DRAIN: begin
            end
            STORE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returns are only accepted while a fill is outstanding.
        if ((state_q == ISSUE || state_q == DRAIN) && bus.mem_data_valid) begin
            ret_valid_c = 1'b1;
            ret_cnt_d   = ret_cnt_q + CNT_W'(1);
            if (ret_cnt_q == LAST_IDX) begin
                last_ret_c  = 1'b1;
                ret_cnt_d   = '0;
                issue_cnt_d = '0;
                ic_busy_d   = 1'b0;
                dc_busy_d   = 1'b0;
                rr_last_d   = owner_q;
                state_d     = IDLE;
            end
        end
    end

    assign bus.ic_busy       = ic_busy_q;
    assign bus.dc_busy       = dc_busy_q;
    assign bus.mem_enable    = mem_enable_q;
    assign bus.mem_wr        = mem_wr_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_data_out  = mem_data_out_q;
    assign bus.st_ack        = st_ack_q;

    // Return path is a same-cycle pass-through to the fill owner.
    assign bus.ic_data_valid = ret_valid_c && (owner_q == OWN_IC);
    assign bus.dc_data_valid = ret_valid_c && (owner_q == OWN_DC);
    assign bus.fill_word     = ret_valid_c ? ret_cnt_q : '0;
    assign bus.fill_data     = ret_valid_c ? bus.mem_data_in : '0;
    assign bus.ic_done       = last_ret_c && (owner_q == OWN_IC);
    assign bus.dc_done       = last_ret_c && (owner_q == OWN_DC);

    // In-order fixed-latency memory: while still issuing, the return index
    // trails the issue index by exactly MEM_LAT.
    a_ret_trails_issue: assert property (@(posedge clk) disable iff (rst)
        (ret_valid_c && state_q == ISSUE) |-> (32'(issue_cnt_q) == 32'(ret_cnt_q) + MEM_LAT));
endmodule
